pri_encoder_seq: RTL and testbench

Parametrised, registered priority encoder that accepts a request vector over a valid/ready handshake and emits the index of every set bit, one per output beat, in priority order. It replaces the combinational 8-to-3 priority encoder wherever all pending requests must be served, not just the winner. Typical users are interrupt and event dispatch logic that must drain a captured request word under backpressure.

---
 rtl/pri_encoder_seq.sv | 192 +++++++++++++++++++
 tb/tb_pri_encoder_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pri_encoder_seq.sv
// pri_encoder_seq
//
// Registered priority encoder that captures a request vector over a
// valid/ready handshake and then emits the index of every set bit, one per
// output beat, in priority order. The final beat of a vector may overlap
// with the acceptance of the next vector, so back-to-back vectors drain
// without an idle cycle.
//
// Parameters:
//   WIDTH      number of request bits (>= 2)
//   IDX_W      width of the emitted index
//   HIGH_FIRST 1: bit WIDTH-1 has highest priority, 0: bit 0 has highest
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request vector present
//   in_ready   block can accept a vector this cycle (combinational from out_ready)
//   in_vec     request vector, sampled only at the accepting edge
//   out_valid  out_idx holds a pending index
//   out_ready  consumer accepts the current index
//   out_idx    index of the highest-priority pending bit
//   out_last   current beat is the final set bit of the vector
//   none       one-cycle pulse: an all-zero vector was accepted
//   remaining  set bits still pending including the current beat
//              (present only when PRI_ENC_COUNT_EN is defined)
//
// Optional feature macro: PRI_ENC_COUNT_EN adds the remaining port and its
// popcount/decrement logic.

module pri_encoder_seq #(
    parameter int WIDTH      = 8,
    parameter int IDX_W      = $clog2(WIDTH),
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             none
`ifdef PRI_ENC_COUNT_EN
    ,
    output logic [IDX_W:0]   remaining
`endif
);

    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] pend_r;
    logic [WIDTH-1:0] pend_nxt_s;
    logic [IDX_W-1:0] out_idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic             out_last_r;
    logic             last_nxt_s;
    logic             none_r;
    logic             none_nxt_s;
    logic             beat_s;
    logic             accept_s;
    logic             in_ready_s;

    // Highest-priority set bit; later loop iterations override earlier ones,
    // so the loop direction encodes the priority order.
    function automatic logic [IDX_W-1:0] pick_idx(input logic [WIDTH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        if (HIGH_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                idx = vec[i] ? IDX_W'(i) : idx;
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                idx = vec[i] ? IDX_W'(i) : idx;
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of vec is set.
    function automatic logic single_bit(input logic [WIDTH-1:0] vec);
        return (vec != ZERO_V) && ((vec & (vec - ONE_V)) == ZERO_V);
    endfunction

    assign beat_s     = (state_r == ST_SERVE) && out_ready;
    // The final beat frees the block in the same cycle, hence the
    // combinational dependence on out_ready.
    assign in_ready_s = (state_r == ST_IDLE) || (beat_s && out_last_r);
    assign accept_s   = in_valid && in_ready_s;

    // Next pending vector, next state and next output beat.
    always_comb begin
        pend_nxt_s  = pend_r;
        state_nxt_s = state_r;
        none_nxt_s  = accept_s && (in_vec == ZERO_V);
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    pend_nxt_s = in_vec;
                end else begin
                    pend_nxt_s = ZERO_V;
                end
            end
            ST_SERVE: begin
                if (beat_s && out_last_r) begin
                    pend_nxt_s = accept_s ? in_vec : ZERO_V;
                end else if (beat_s) begin
                    pend_nxt_s = pend_r & ~(ONE_V << out_idx_r);
                end else begin
                    pend_nxt_s = pend_r;
                end
            end
            default: begin
                pend_nxt_s = ZERO_V;
            end
        endcase
        state_nxt_s = (pend_nxt_s != ZERO_V) ? ST_SERVE : ST_IDLE;
        idx_nxt_s   = pick_idx(pend_nxt_s);
        last_nxt_s  = single_bit(pend_nxt_s);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pending vector and registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r     <= ZERO_V;
            out_idx_r  <= {IDX_W{1'b0}};
            out_last_r <= 1'b0;
            none_r     <= 1'b0;
        end else begin
            pend_r     <= pend_nxt_s;
            out_idx_r  <= idx_nxt_s;
            out_last_r <= last_nxt_s;
            none_r     <= none_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == ST_SERVE);
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign none      = none_r;

`ifdef PRI_ENC_COUNT_EN
    logic [IDX_W:0] rem_r;

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] vec);
        logic [IDX_W:0] cnt;
        cnt = {(IDX_W + 1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Pending-bit count: loaded on accept (which wins over a coincident
    // final beat), decremented per beat, naturally 0 once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r <= {(IDX_W + 1){1'b0}};
        end else if (accept_s) begin
            rem_r <= popcount(in_vec);
        end else if (beat_s) begin
            rem_r <= rem_r - {{IDX_W{1'b0}}, 1'b1};
        end else begin
            rem_r <= rem_r;
        end
    end

    assign remaining = rem_r;
`endif

endmodule

// File: tb/tb_pri_encoder_seq.sv
// Bench for pri_encoder_seq: two instances (WIDTH=8 high-first and
// WIDTH=16 low-first) share one stimulus stream. A list-based model holds,
// per instance, the ordered list of indices still to be emitted; a compare
// process checks every output against it on each falling edge, and
// literal expectations pin the model to hand-computed values.

module tb_pri_encoder_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_vec;

    logic        rdy8, val8, last8, none8;
    logic [2:0]  idx8;
    logic        rdy16, val16, last16, none16;
    logic [3:0]  idx16;
`ifdef PRI_ENC_COUNT_EN
    logic [3:0]  rem8;
    logic [4:0]  rem16;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Model: lst[d][head[d] .. len[d]-1] are the indices still to emit.
    int lst [2][16];
    int head [2];
    int len [2];
    bit none_e [2];

    always #5 clk = ~clk;

    pri_encoder_seq #(.WIDTH(8), .HIGH_FIRST(1'b1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
        .in_vec(in_vec[7:0]), .out_valid(val8), .out_ready(out_ready),
        .out_idx(idx8), .out_last(last8), .none(none8)
`ifdef PRI_ENC_COUNT_EN
        , .remaining(rem8)
`endif
    );

    pri_encoder_seq #(.WIDTH(16), .HIGH_FIRST(1'b0)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
        .in_vec(in_vec), .out_valid(val16), .out_ready(out_ready),
        .out_idx(idx16), .out_last(last16), .none(none16)
`ifdef PRI_ENC_COUNT_EN
        , .remaining(rem16)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            head[d]   = 0;
            len[d]    = 0;
            none_e[d] = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the inputs seen there.
    task automatic model_clock();
        for (int d = 0; d < 2; d++) begin
            int w;
            bit hf;
            int p;
            bit beat;
            bit rdy;
            bit acc;
            w    = (d == 0) ? 8 : 16;
            hf   = (d == 0);
            p    = len[d] - head[d];
            beat = (p > 0) && out_ready;
            rdy  = (p == 0) || (beat && p == 1);
            acc  = in_valid && rdy;
            none_e[d] = 1'b0;
            if (beat) head[d]++;
            if (acc) begin
                head[d] = 0;
                len[d]  = 0;
                for (int k = 0; k < w; k++) begin
                    int b;
                    b = hf ? (w - 1 - k) : k;
                    if (in_vec[b]) begin
                        lst[d][len[d]] = b;
                        len[d]++;
                    end
                end
                none_e[d] = (len[d] == 0);
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model.
    task automatic step(input bit v, input logic [15:0] vec, input bit rdy);
        in_valid  = v;
        in_vec    = vec;
        out_ready = rdy;
        @(posedge clk);
        if (rst_n) model_clock();
        else model_clear();
        #2;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin : cmp
        int p0;
        int p1;
        p0 = len[0] - head[0];
        p1 = len[1] - head[1];
        check("valid8", val8, int'(p0 > 0));
        check("ready8", rdy8, int'((p0 == 0) || (out_ready && p0 == 1)));
        check("none8", none8, none_e[0]);
        if (p0 > 0) begin
            check("idx8", idx8, lst[0][head[0]]);
            check("last8", last8, int'(p0 == 1));
        end
        check("valid16", val16, int'(p1 > 0));
        check("ready16", rdy16, int'((p1 == 0) || (out_ready && p1 == 1)));
        check("none16", none16, none_e[1]);
        if (p1 > 0) begin
            check("idx16", idx16, lst[1][head[1]]);
            check("last16", last16, int'(p1 == 1));
        end
`ifdef PRI_ENC_COUNT_EN
        check("rem8", rem8, p0);
        check("rem16", rem16, p1);
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_vec = 16'h0000;
        out_ready = 1'b1;
        model_clear();
        repeat (2) step(1'b0, 16'h0000, 1'b1);
        check("lit_rst_valid", val8, 0);
        check("lit_rst_idx", idx8, 0);
        check("lit_rst_last", last8, 0);
        check("lit_rst_none", none8, 0);
        check("lit_rst_ready", rdy8, 1);
`ifdef PRI_ENC_COUNT_EN
        check("lit_rst_rem", rem8, 0);
`endif
        rst_n = 1'b1;
        step(1'b0, 16'h0000, 1'b1);

        // 8'h43 at full throughput: 6, 1, 0 (high-first); 0, 1, 6 (low-first)
        step(1'b1, 16'h0043, 1'b1);
        check("lit_43_idx_a", idx8, 6);
        check("lit_43_last_a", last8, 0);
        check("lit_43_idx16_a", idx16, 0);
`ifdef PRI_ENC_COUNT_EN
        check("lit_43_rem_a", rem8, 3);
`endif
        step(1'b0, 16'h0000, 1'b1);
        check("lit_43_idx_b", idx8, 1);
        step(1'b0, 16'h0000, 1'b1);
        check("lit_43_idx_c", idx8, 0);
        check("lit_43_last_c", last8, 1);
        check("lit_43_idx16_c", idx16, 6);
`ifdef PRI_ENC_COUNT_EN
        check("lit_43_rem_c", rem8, 1);
`endif
        step(1'b0, 16'h0000, 1'b1);
        check("lit_43_done", val8, 0);

        // 8'hA5 under backpressure; in_vec noise must be ignored
        step(1'b1, 16'h00A5, 1'b0);
        check("lit_a5_idx_a", idx8, 7);
        step(1'b0, 16'hFFFF, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        check("lit_a5_hold_idx", idx8, 7);
        check("lit_a5_hold_valid", val8, 1);
        check("lit_a5_hold_ready", rdy8, 0);
        step(1'b0, 16'h0000, 1'b1);
        check("lit_a5_idx_b", idx8, 5);
        step(1'b0, 16'h0000, 1'b1);
        check("lit_a5_idx_c", idx8, 2);
        step(1'b0, 16'h0000, 1'b1);
        check("lit_a5_idx_d", idx8, 0);
        check("lit_a5_last_d", last8, 1);
        step(1'b0, 16'h0000, 1'b1);
        check("lit_a5_done", val8, 0);

        // all-zero vector
        step(1'b1, 16'h0000, 1'b1);
        check("lit_zero_none", none8, 1);
        check("lit_zero_valid", val8, 0);
        check("lit_zero_ready", rdy8, 1);
        step(1'b0, 16'h0000, 1'b1);
        check("lit_zero_none_end", none8, 0);

        // back-to-back: final beat of 8'h80 overlaps accept of 8'h01
        step(1'b1, 16'h0080, 1'b1);
        check("lit_b2b_idx_a", idx8, 7);
        check("lit_b2b_last_a", last8, 1);
        in_valid = 1'b1;
        in_vec = 16'h0001;
        out_ready = 1'b1;
        #1;
        check("lit_b2b_ready", rdy8, 1);
        step(1'b1, 16'h0001, 1'b1);
        check("lit_b2b_valid_b", val8, 1);
        check("lit_b2b_idx_b", idx8, 0);
        step(1'b0, 16'h0000, 1'b1);
        check("lit_b2b_done", val8, 0);

        // 16'h8001 on the low-first instance: 0 then 15
        step(1'b1, 16'h8001, 1'b1);
        check("lit_8001_idx_a", idx16, 0);
        check("lit_8001_last_a", last16, 0);
        step(1'b0, 16'h0000, 1'b1);
        check("lit_8001_idx_b", idx16, 15);
        check("lit_8001_last_b", last16, 1);
        step(1'b0, 16'h0000, 1'b1);

        // 8'hFF, reset after two beats discards the rest
        step(1'b1, 16'h00FF, 1'b1);
        check("lit_ff_idx_a", idx8, 7);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        check("lit_ff_idx_c", idx8, 5);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("lit_ff_rst_valid", val8, 0);
        check("lit_ff_rst_ready", rdy8, 1);
        check("lit_ff_rst_valid16", val16, 0);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 16'h0000, 1'b1);
        check("lit_ff_after_valid", val8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
